// File: rtl/usb_link_ctl_if.sv
// AXI-Lite write-only CSR link between the link controller and the ULPI controller.
// The read channel carries only its two master-side request signals, held low.
interface axi_lite_iface;
    logic [5:0] awaddr;
    logic       awvalid;
    logic       awready;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready;
    logic       arvalid;
    logic       rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, arvalid, rready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, arvalid, rready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/usb_link_ctl.sv
// Full-speed device link controller: PHY init/attach/detach via CSR writes and
// bus reset / suspend / resume detection from the reported line state.
module usb_link_ctl #(
    parameter int         RESET_CYCLES   = 150,
    parameter int         SUSPEND_CYCLES = 180000,
    parameter logic [7:0] FC_ATTACHED    = 8'h45,
    parameter logic [7:0] FC_DETACHED    = 8'h49
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        line_state,
    input  logic [1:0]        vbus_state,
    input  logic              rx_active,
    input  logic              connect_en,
    axi_lite_iface.master     ulpi_csr,
    output logic              attached,
    output logic              bus_reset,
    output logic              bus_reset_start,
    output logic              suspended,
    output logic              resume,
    output logic              csr_busy,
    output logic              csr_err
);

    localparam logic [2:0] S_INIT_OTG  = 3'd0;
    localparam logic [2:0] S_INIT_FC   = 3'd1;
    localparam logic [2:0] S_DETACHED  = 3'd2;
    localparam logic [2:0] S_ATTACH_WR = 3'd3;
    localparam logic [2:0] S_ATTACHED  = 3'd4;
    localparam logic [2:0] S_DETACH_WR = 3'd5;

    localparam int             CW    = $clog2(SUSPEND_CYCLES + 1);
    localparam logic [CW-1:0]  RST_C = CW'(RESET_CYCLES);
    localparam logic [CW-1:0]  SUS_C = CW'(SUSPEND_CYCLES);

    localparam logic [5:0] REG_OTG_CTL = 6'h0A;
    localparam logic [5:0] REG_FC      = 6'h04;

    logic [2:0]    state, state_nxt;
    logic          start_wr;
    logic [5:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          b_done;
    logic          aw_left, w_left;
    logic          vbus_ok;
    logic          mon_on;
    logic [CW-1:0] se0_cnt, j_cnt;

    assign vbus_ok = (vbus_state == 2'b11);
    assign b_done  = ulpi_csr.bvalid & ulpi_csr.bready;
    assign aw_left = ulpi_csr.awvalid & ~ulpi_csr.awready;
    assign w_left  = ulpi_csr.wvalid & ~ulpi_csr.wready;

    assign ulpi_csr.arvalid = 1'b0;
    assign ulpi_csr.rready  = 1'b0;

    // Each write state issues exactly one write; busy gates re-issue until B returns.
    always_comb begin
        start_wr = 1'b0;
        wr_addr  = 6'h00;
        wr_data  = 8'h00;
        case (state)
            S_INIT_OTG: begin
                start_wr = ~csr_busy;
                wr_addr  = REG_OTG_CTL;
                wr_data  = 8'h00;
            end
            S_INIT_FC: begin
                start_wr = ~csr_busy;
                wr_addr  = REG_FC;
                wr_data  = FC_DETACHED;
            end
            S_ATTACH_WR: begin
                start_wr = ~csr_busy;
                wr_addr  = REG_FC;
                wr_data  = FC_ATTACHED;
            end
            S_DETACH_WR: begin
                start_wr = ~csr_busy;
                wr_addr  = REG_FC;
                wr_data  = FC_DETACHED;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT_OTG:  if (b_done) state_nxt = S_INIT_FC;
            S_INIT_FC:   if (b_done) state_nxt = S_DETACHED;
            S_DETACHED:  if (connect_en && vbus_ok) state_nxt = S_ATTACH_WR;
            S_ATTACH_WR: if (b_done) state_nxt = S_ATTACHED;
            S_ATTACHED:  if (!connect_en || !vbus_ok) state_nxt = S_DETACH_WR;
            S_DETACH_WR: if (b_done) state_nxt = S_DETACHED;
            default:     state_nxt = S_INIT_OTG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_INIT_OTG;
            csr_busy         <= 1'b0;
            csr_err          <= 1'b0;
            attached         <= 1'b0;
            ulpi_csr.awvalid <= 1'b0;
            ulpi_csr.wvalid  <= 1'b0;
            ulpi_csr.bready  <= 1'b0;
            ulpi_csr.awaddr  <= 6'h00;
            ulpi_csr.wdata   <= 8'h00;
        end else begin
            state <= state_nxt;
            if (start_wr) begin
                csr_busy         <= 1'b1;
                ulpi_csr.awvalid <= 1'b1;
                ulpi_csr.wvalid  <= 1'b1;
                ulpi_csr.awaddr  <= wr_addr;
                ulpi_csr.wdata   <= wr_data;
            end else if (csr_busy) begin
                if (ulpi_csr.awvalid && ulpi_csr.awready) ulpi_csr.awvalid <= 1'b0;
                if (ulpi_csr.wvalid && ulpi_csr.wready)   ulpi_csr.wvalid  <= 1'b0;
                if (!ulpi_csr.bready && !aw_left && !w_left) ulpi_csr.bready <= 1'b1;
                if (b_done) begin
                    ulpi_csr.bready <= 1'b0;
                    csr_busy        <= 1'b0;
                    if (ulpi_csr.bresp != 2'b00) csr_err <= 1'b1;
                end
            end
            if (state == S_ATTACH_WR && b_done)   attached <= 1'b1;
            if (state == S_DETACH_WR && start_wr) attached <= 1'b0;
        end
    end

    // A pending detach wins over any line event in the same cycle.
    assign mon_on = (state == S_ATTACHED) && connect_en && vbus_ok;

    always_ff @(posedge clk) begin
        if (!rst_n || !mon_on) begin
            se0_cnt         <= '0;
            j_cnt           <= '0;
            bus_reset       <= 1'b0;
            bus_reset_start <= 1'b0;
            suspended       <= 1'b0;
            resume          <= 1'b0;
        end else begin
            bus_reset_start <= 1'b0;
            resume          <= 1'b0;

            if (line_state == 2'b00)
                se0_cnt <= (se0_cnt == RST_C) ? se0_cnt : se0_cnt + 1'b1;
            else
                se0_cnt <= '0;

            if (line_state == 2'b01 && !rx_active)
                j_cnt <= (j_cnt == SUS_C) ? j_cnt : j_cnt + 1'b1;
            else
                j_cnt <= '0;

            if (suspended && line_state == 2'b10) begin
                suspended <= 1'b0;
                resume    <= 1'b1;
            end else if (j_cnt == SUS_C && !suspended) begin
                suspended <= 1'b1;
            end

            // Bus reset ends suspend silently, so it overrides the resume path.
            if (se0_cnt == RST_C && !bus_reset) begin
                bus_reset_start <= 1'b1;
                bus_reset       <= 1'b1;
                suspended       <= 1'b0;
                resume          <= 1'b0;
            end else if (bus_reset && line_state != 2'b00) begin
                bus_reset <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_link_ctl.sv
// Bench for usb_link_ctl: reactive AXI-Lite slave feeding an observed-write queue
// that is matched against expected writes queued as stimulus is applied.
module tb_usb_link_ctl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] line_state;
    logic [1:0] vbus_state;
    logic       rx_active;
    logic       connect_en;
    logic       attached, bus_reset, bus_reset_start, suspended, resume, csr_busy, csr_err;

    axi_lite_iface csr ();

    usb_link_ctl #(
        .RESET_CYCLES   (150),
        .SUSPEND_CYCLES (1000),
        .FC_ATTACHED    (8'h45),
        .FC_DETACHED    (8'h49)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .line_state      (line_state),
        .vbus_state      (vbus_state),
        .rx_active       (rx_active),
        .connect_en      (connect_en),
        .ulpi_csr        (csr),
        .attached        (attached),
        .bus_reset       (bus_reset),
        .bus_reset_start (bus_reset_start),
        .suspended       (suspended),
        .resume          (resume),
        .csr_busy        (csr_busy),
        .csr_err         (csr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];

    int         slv_dly = 3;
    logic [1:0] slv_bresp = 2'b00;
    logic       aw_got, w_got;
    logic [5:0] aw_q;
    logic [7:0] w_q;
    int         aw_cnt, w_cnt, b_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            csr.awready <= 1'b0; csr.wready <= 1'b0; csr.bvalid <= 1'b0; csr.bresp <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0; aw_q <= '0; w_q <= '0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
        end else begin
            csr.awready <= 1'b0;
            csr.wready  <= 1'b0;
            if (csr.awvalid && !csr.awready && !aw_got) begin
                if (aw_cnt >= slv_dly) begin csr.awready <= 1'b1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (csr.wvalid && !csr.wready && !w_got) begin
                if (w_cnt >= slv_dly) begin csr.wready <= 1'b1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (csr.awvalid && csr.awready) begin aw_got <= 1'b1; aw_q <= csr.awaddr; end
            if (csr.wvalid && csr.wready)   begin w_got <= 1'b1;  w_q <= csr.wdata; end
            if (aw_got && w_got && !csr.bvalid) begin
                if (b_cnt >= slv_dly) begin
                    csr.bvalid <= 1'b1;
                    csr.bresp  <= slv_bresp;
                    b_cnt      <= 0;
                    obs_q.push_back({aw_q, w_q});
                end else b_cnt <= b_cnt + 1;
            end
            if (csr.bvalid && csr.bready) begin
                csr.bvalid <= 1'b0;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (obs_q.size() > 0) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!csr_busy) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; line_state = 2'b10; vbus_state = 2'b00; rx_active = 1'b0; connect_en = 1'b0;
        repeat (3) tick();
        checks++;
        if ({csr.awvalid, csr.wvalid, csr.bready, csr.arvalid, csr.rready, csr.awaddr, csr.wdata,
             attached, bus_reset, bus_reset_start, suspended, resume, csr_busy, csr_err} !== '0) begin
            failures++;
            $display("FAIL reset_state: awv=%b wv=%b br=%b addr=%h data=%h att=%b busy=%b err=%b (all must be 0)",
                     csr.awvalid, csr.wvalid, csr.bready, csr.awaddr, csr.wdata, attached, csr_busy, csr_err);
        end
        rst_n = 1'b1;
        exp_q.push_back({6'h0A, 8'h00});
        exp_q.push_back({6'h04, 8'h49});
        tick();
        checks++;
        if ({csr.awvalid, csr.wvalid, csr_busy, csr.awaddr} !== {3'b111, 6'h0A}) begin
            failures++;
            $display("FAIL first_write_start: awv=%b wv=%b busy=%b addr=%h (need 1 1 1 0a)",
                     csr.awvalid, csr.wvalid, csr_busy, csr.awaddr);
        end
    endtask

    task automatic test_init();
        bit ok;
        logic [13:0] got, e;
        for (int n = 0; n < 2; n++) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL init_write%0d: timeout, no write observed", n);
            end else begin
                got = obs_q.pop_front(); e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL init_write%0d: got addr=%h data=%h need addr=%h data=%h", n, got[13:8], got[7:0], e[13:8], e[7:0]);
                end
            end
        end
        repeat (60) tick();
        checks++;
        if (obs_q.size() != 0 || attached !== 1'b0 || csr_busy !== 1'b0) begin
            failures++;
            $display("FAIL init_quiet: extra writes=%0d attached=%b busy=%b (need 0 0 0)", obs_q.size(), attached, csr_busy);
        end
    endtask

    task automatic attach_up(input string tag);
        bit ok;
        logic [13:0] got, e;
        vbus_state = 2'b11; connect_en = 1'b1;
        exp_q.push_back({6'h04, 8'h45});
        wait_obs(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_attach_write: timeout", tag);
            return;
        end
        got = obs_q.pop_front(); e = exp_q.pop_front();
        if (got !== e) begin
            failures++;
            $display("FAIL %s_attach_write: got %h need %h", tag, got, e);
        end
        for (int i = 0; i < 50; i++) begin
            if (csr.bvalid && csr.bready) break;
            tick();
        end
        checks++;
        if (attached !== 1'b0 || csr_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_attach_early: attached=%b busy=%b at B handshake (need 0 1)", tag, attached, csr_busy);
        end
        tick();
        checks++;
        if (attached !== 1'b1 || csr_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_attach_level: attached=%b busy=%b after B (need 1 0)", tag, attached, csr_busy);
        end
    endtask

    task automatic test_attach_vbus();
        bit ok;
        logic [13:0] got, e;
        attach_up("vbus");
        vbus_state = 2'b00;
        exp_q.push_back({6'h04, 8'h49});
        wait_obs(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL detach_write: timeout");
        end else begin
            got = obs_q.pop_front(); e = exp_q.pop_front();
            if (got !== e || attached !== 1'b0) begin
                failures++;
                $display("FAIL detach_write: got %h attached=%b need %h attached=0", got, attached, e);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || attached !== 1'b0) begin
            failures++;
            $display("FAIL detach_done: idle=%b attached=%b (need 1 0)", ok, attached);
        end
    endtask

    task automatic test_bus_reset();
        int pulses;
        int first;
        attach_up("brst");
        pulses = 0;
        line_state = 2'b00;
        for (int i = 1; i <= 149; i++) begin
            tick();
            if (bus_reset_start) pulses++;
        end
        line_state = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_reset_start || bus_reset) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL brst_149: saw %0d reset cycles after 149 SE0 cycles (need 0)", pulses);
        end
        line_state = 2'b10;
        tick();
        line_state = 2'b00;
        first = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus_reset_start) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (pulses != 1 || first != 151) begin
            failures++;
            $display("FAIL brst_pulse: pulses=%0d first_cycle=%0d (need 1 at 151)", pulses, first);
        end
        checks++;
        if (bus_reset !== 1'b1) begin
            failures++;
            $display("FAIL brst_level: bus_reset=%b while SE0 held (need 1)", bus_reset);
        end
        line_state = 2'b01;
        tick();
        checks++;
        if (bus_reset !== 1'b0) begin
            failures++;
            $display("FAIL brst_end: bus_reset=%b after J (need 0)", bus_reset);
        end
        line_state = 2'b10;
        tick();
    endtask

    task automatic test_suspend();
        int first;
        first = 0;
        line_state = 2'b01;
        for (int i = 1; i <= 1520; i++) begin
            rx_active = (i == 500);
            tick();
            if (suspended && first == 0) first = i;
            if (first != 0) break;
        end
        rx_active = 1'b0;
        checks++;
        if (first != 1501) begin
            failures++;
            $display("FAIL suspend_detect: suspended at cycle %0d (need 1501)", first);
        end
        line_state = 2'b10;
        tick();
        checks++;
        if (resume !== 1'b1 || suspended !== 1'b0) begin
            failures++;
            $display("FAIL resume_pulse: resume=%b suspended=%b (need 1 0)", resume, suspended);
        end
        tick();
        checks++;
        if (resume !== 1'b0) begin
            failures++;
            $display("FAIL resume_width: resume=%b second cycle (need 0)", resume);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        bit seen;
        logic [13:0] got, e;
        slv_dly = 20;
        connect_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (csr.awvalid && !csr.awready) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midwr_pending: awvalid never pending");
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({csr.awvalid, csr.wvalid, csr.bready, csr_busy, attached} !== 5'b0) begin
            failures++;
            $display("FAIL midwr_drop: awv=%b wv=%b br=%b busy=%b att=%b (need all 0)",
                     csr.awvalid, csr.wvalid, csr.bready, csr_busy, attached);
        end
        tick();
        obs_q.delete();
        exp_q.delete();
        slv_dly = 3;
        rst_n = 1'b1;
        exp_q.push_back({6'h0A, 8'h00});
        exp_q.push_back({6'h04, 8'h49});
        for (int n = 0; n < 2; n++) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL midwr_restart%0d: timeout", n);
            end else begin
                got = obs_q.pop_front(); e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL midwr_restart%0d: got %h need %h", n, got, e);
                end
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_bresp_err();
        bit ok;
        logic [13:0] got, e;
        checks++;
        if (csr_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: csr_err=%b before error (need 0)", csr_err);
        end
        slv_bresp = 2'b10;
        attach_up("err");
        checks++;
        if (csr_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: csr_err=%b after SLVERR (need 1)", csr_err);
        end
        slv_bresp = 2'b00;
        connect_en = 1'b0;
        exp_q.push_back({6'h04, 8'h49});
        wait_obs(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL err_detach: timeout");
        end else begin
            got = obs_q.pop_front(); e = exp_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL err_detach: got %h need %h", got, e);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || csr_err !== 1'b1 || attached !== 1'b0) begin
            failures++;
            $display("FAIL err_sticky: idle=%b csr_err=%b attached=%b (need 1 1 0)", ok, csr_err, attached);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_attach_vbus();
        test_bus_reset();
        test_suspend();
        test_reset_mid_write();
        test_bresp_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
